boc_acq_search: RTL

Parametrised serial/parallel acquisition engine for the B1 BOC data channel. It searches a code-phase × Doppler grid and owns NUM_CORR parallel I/Q correlator lanes. It steers the existing carrier NCO (FCW) and PRN generators (phase load). After the full grid is searched it reports the strongest peak, its code phase and its Doppler bin. It replaces the fixed four-lane acquisition top and adds a search FSM, Doppler stepping, magnitude detection, thresholding and a start/done handshake.

---
 rtl/boc_acq_pkg.sv | 46 ++++
 rtl/boc_corr_lane.sv | 59 +++++
 rtl/boc_acq_search.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/boc_acq_pkg.sv
// Shared definitions for the B1 BOC acquisition engine: FSM encodings,
// sizing helper, saturating magnitude and the BOC chip sign convention.
package boc_acq_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] S_DWELL = 3'd2;
  localparam logic [STATE_W-1:0] S_EVAL  = 3'd3;
  localparam logic [STATE_W-1:0] S_NEXT  = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

  // Local chip value that maps to +1; the other value maps to -1.
  localparam logic BOC_POS = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    if (v > 1) begin
      x = v - 1;
      while (x > 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

  // |i|+|q| evaluated one bit wider than w, then clamped to 2^w-1.
  function automatic logic [63:0] sat_mag(input logic signed [63:0] i_v,
                                          input logic signed [63:0] q_v,
                                          input int unsigned        w);
    logic [64:0] a_i;
    logic [64:0] a_q;
    logic [64:0] sum;
    logic [64:0] lim;
    a_i = {1'b0, (i_v[63] ? 64'(-i_v) : 64'(i_v))};
    a_q = {1'b0, (q_v[63] ? 64'(-q_v) : 64'(q_v))};
    sum = a_i + a_q;
    lim = (65'(1) << w) - 65'(1);
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/boc_corr_lane.sv
// One I/Q multiply-accumulate correlator lane: the BOC chip flips the IF
// sample sign, which is then mixed with the carrier replica and accumulated.
module boc_corr_lane
  import boc_acq_pkg::*;
#(
  parameter int unsigned SRC_WIDTH  = 8,
  parameter int unsigned CAR_WIDTH  = 4,
  parameter int unsigned CORR_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [SRC_WIDTH-1:0]  src_i,
  input  logic signed [CAR_WIDTH-1:0]  cos_i,
  input  logic signed [CAR_WIDTH-1:0]  sin_i,
  input  logic                         boc_i,
  output logic signed [CORR_WIDTH-1:0] i_acc_o,
  output logic signed [CORR_WIDTH-1:0] q_acc_o
);

  localparam int unsigned S_W    = SRC_WIDTH + 1;
  localparam int unsigned PROD_W = S_W + CAR_WIDTH;

  logic signed [S_W-1:0]        s_c;
  logic signed [PROD_W-1:0]     pi_c;
  logic signed [PROD_W-1:0]     pq_c;
  logic signed [CORR_WIDTH-1:0] i_q, i_d;
  logic signed [CORR_WIDTH-1:0] q_q, q_d;

  always_comb begin
    s_c  = (boc_i == BOC_POS) ? S_W'(src_i) : -S_W'(src_i);
    pi_c = s_c * cos_i;
    pq_c = s_c * sin_i;
    i_d  = i_q;
    q_d  = q_q;
    if (clr_i) begin
      i_d = '0;
      q_d = '0;
    end else if (en_i) begin
      i_d = i_q + CORR_WIDTH'(pi_c);
      q_d = q_q + CORR_WIDTH'(pq_c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q <= '0;
      q_q <= '0;
    end else begin
      i_q <= i_d;
      q_q <= q_d;
    end
  end

  assign i_acc_o = i_q;
  assign q_acc_o = q_q;

endmodule

// File: rtl/boc_acq_search.sv
// Code-phase x Doppler grid search for the B1 BOC data channel: steers the
// carrier NCO and PRN generators, correlates NUM_CORR phases per dwell and
// keeps the strongest peak.
module boc_acq_search
  import boc_acq_pkg::*;
#(
  parameter int unsigned NUM_CORR      = 4,
  parameter int unsigned SRC_WIDTH     = 8,
  parameter int unsigned CAR_WIDTH     = 4,
  parameter int unsigned CORR_WIDTH    = 32,
  parameter int unsigned PRN_PHS_WIDTH = 12,
  parameter int unsigned CODE_PHS_MAX  = 4092,
  parameter int unsigned DWELL_LEN     = 4092,
  parameter int unsigned DOP_BINS      = 16,
  parameter int unsigned FCW_WIDTH     = 32,
  localparam int unsigned BIN_W        = (DOP_BINS > 1) ? clog2(DOP_BINS) : 1
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst,
  input  logic                        rx_start,
  input  logic signed [SRC_WIDTH-1:0] rx_src,
  input  logic                        rx_src_vld,
  input  logic signed [CAR_WIDTH-1:0] rx_car_cos,
  input  logic signed [CAR_WIDTH-1:0] rx_car_sin,
  input  logic [NUM_CORR-1:0]         rx_loc_boc,
  input  logic [FCW_WIDTH-1:0]        rx_fcw_base,
  input  logic [FCW_WIDTH-1:0]        rx_fcw_step,
  input  logic [CORR_WIDTH-1:0]       rx_thresh,
  output logic [FCW_WIDTH-1:0]        tx_car_fcw,
  output logic                        tx_prn_load,
  output logic [PRN_PHS_WIDTH-1:0]    tx_prn_phs,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        tx_hit,
  output logic [CORR_WIDTH-1:0]       tx_corr_peak,
  output logic [PRN_PHS_WIDTH-1:0]    tx_acq_prn_phs,
  output logic [BIN_W-1:0]            tx_acq_dop_bin
);

  localparam int unsigned CNT_W  = clog2(DWELL_LEN + 1);
  localparam int unsigned LANE_W = (NUM_CORR > 1) ? clog2(NUM_CORR) : 1;

  logic [STATE_W-1:0]       state_q, state_d;
  logic [PRN_PHS_WIDTH-1:0] phs_q, phs_d;
  logic [BIN_W-1:0]         bin_q, bin_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [FCW_WIDTH-1:0]     fcw_q, fcw_d;
  logic [FCW_WIDTH-1:0]     step_q, step_d;
  logic [CORR_WIDTH-1:0]    thresh_q, thresh_d;
  logic [CORR_WIDTH-1:0]    peak_q, peak_d;
  logic [PRN_PHS_WIDTH-1:0] acq_phs_q, acq_phs_d;
  logic [BIN_W-1:0]         acq_bin_q, acq_bin_d;
  logic                     hit_q, hit_d;
  logic                     load_q, load_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                         lane_clr_c;
  logic                         lane_en_c;
  logic signed [CORR_WIDTH-1:0] acc_i_c [NUM_CORR];
  logic signed [CORR_WIDTH-1:0] acc_q_c [NUM_CORR];
  logic [CORR_WIDTH-1:0]        mag_c;

  for (genvar g = 0; g < NUM_CORR; g++) begin : g_lane
    boc_corr_lane #(
      .SRC_WIDTH  (SRC_WIDTH),
      .CAR_WIDTH  (CAR_WIDTH),
      .CORR_WIDTH (CORR_WIDTH)
    ) u_lane (
      .clk_i   (rx_clk),
      .rst_i   (rx_rst),
      .clr_i   (lane_clr_c),
      .en_i    (lane_en_c),
      .src_i   (rx_src),
      .cos_i   (rx_car_cos),
      .sin_i   (rx_car_sin),
      .boc_i   (rx_loc_boc[g]),
      .i_acc_o (acc_i_c[g]),
      .q_acc_o (acc_q_c[g])
    );
  end

  // Lanes are scanned one per EVAL cycle so a single magnitude unit suffices.
  always_comb begin
    mag_c = CORR_WIDTH'(sat_mag(64'(acc_i_c[lane_q]), 64'(acc_q_c[lane_q]), CORR_WIDTH));
  end

  always_comb begin
    state_d    = state_q;
    phs_d      = phs_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    fcw_d      = fcw_q;
    step_d     = step_q;
    thresh_d   = thresh_q;
    peak_d     = peak_q;
    acq_phs_d  = acq_phs_q;
    acq_bin_d  = acq_bin_q;
    hit_d      = hit_q;
    lane_clr_c = 1'b0;
    lane_en_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_start) begin
          state_d   = S_LOAD;
          fcw_d     = rx_fcw_base;
          step_d    = rx_fcw_step;
          thresh_d  = rx_thresh;
          phs_d     = '0;
          bin_d     = '0;
          peak_d    = '0;
          acq_phs_d = '0;
          acq_bin_d = '0;
          hit_d     = 1'b0;
        end
      end
      S_LOAD: begin
        lane_clr_c = 1'b1;
        cnt_d      = '0;
        lane_d     = '0;
        state_d    = S_DWELL;
      end
      S_DWELL: begin
        if (rx_src_vld) begin
          lane_en_c = 1'b1;
          if (cnt_q == CNT_W'(DWELL_LEN - 1)) begin
            state_d = S_EVAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_EVAL: begin
        // Strict compare keeps the earliest (bin, phase, lane) on ties.
        if (mag_c > peak_q) begin
          peak_d    = mag_c;
          acq_phs_d = phs_q + PRN_PHS_WIDTH'(lane_q);
          acq_bin_d = bin_q;
        end
        if (lane_q == LANE_W'(NUM_CORR - 1)) begin
          state_d = S_NEXT;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      S_NEXT: begin
        if (32'(phs_q) + NUM_CORR >= CODE_PHS_MAX) begin
          phs_d = '0;
          if (32'(bin_q) + 1 >= DOP_BINS) begin
            state_d = S_DONE;
          end else begin
            bin_d   = bin_q + BIN_W'(1);
            fcw_d   = fcw_q + step_q;
            state_d = S_LOAD;
          end
        end else begin
          phs_d   = phs_q + PRN_PHS_WIDTH'(NUM_CORR);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_DONE) begin
      hit_d = (peak_q >= thresh_q);
    end
    load_d = (state_d == S_LOAD);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q   <= S_IDLE;
      phs_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      fcw_q     <= '0;
      step_q    <= '0;
      thresh_q  <= '0;
      peak_q    <= '0;
      acq_phs_q <= '0;
      acq_bin_q <= '0;
      hit_q     <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phs_q     <= phs_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      fcw_q     <= fcw_d;
      step_q    <= step_d;
      thresh_q  <= thresh_d;
      peak_q    <= peak_d;
      acq_phs_q <= acq_phs_d;
      acq_bin_q <= acq_bin_d;
      hit_q     <= hit_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_car_fcw     = fcw_q;
  assign tx_prn_load    = load_q;
  assign tx_prn_phs     = phs_q;
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;
  assign tx_hit         = hit_q;
  assign tx_corr_peak   = peak_q;
  assign tx_acq_prn_phs = acq_phs_q;
  assign tx_acq_dop_bin = acq_bin_q;

endmodule
